hazard_scoreboard_unit: RTL and testbench

Parametrised hazard detection for the MIPS pipeline. A per-register countdown scoreboard replaces fixed opcode-pair checks, so stalls are exact for any producer latency.
- Generates PC/IF-ID write enables, the ID/EX bubble control (Hazard_Ctrl) and a multi-cycle IF flush sequence.
- Sits beside the ID stage, fed by decode-class signals rather than raw opcodes.

---
 rtl/hazard_scoreboard_unit.sv | 185 ++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard for the MIPS ID stage.
// Each register has a countdown counter. A consumer stalls while a producer's
// result is further away than the consumer's operand slack allows. The unit
// also sequences IF flushes after taken branches and jumps.
// Optional build macro: HAZARD_PERF_EN adds saturating performance counters.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | normal issue; a stall or a redirect is taken from here
// STALL  | ID instruction held while counters drain
// FLUSH  | IF/ID squashed for the remaining FLUSH_CYCLES-1 cycles
module hazard_scoreboard_unit #(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = 5,
  parameter int ALU_LAT      = 1,
  parameter int LOAD_LAT     = 2,
  parameter int EX_SLACK     = 1,
  parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W       = 16
`endif
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ID_valid,
  input  logic [REG_AW-1:0] ID_RS,
  input  logic [REG_AW-1:0] ID_RT,
  input  logic              ID_uses_rs,
  input  logic              ID_uses_rt,
  input  logic              ID_is_branch,
  input  logic              ID_RegWrite,
  input  logic              ID_is_load,
  input  logic [REG_AW-1:0] ID_dst,
  input  logic              Branch,
  input  logic [1:0]        Jump,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IF_Flush,
  output logic              Hazard_Ctrl,
  output logic [1:0]        stall_cause
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_cycles,
  output logic [PERF_W-1:0] branch_stalls
`endif
);

  localparam int MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  logic        squash, hz_rs, hz_rt, stall, issue, redirect;
  logic [31:0] slack;

  // Hazard detection against the registered scoreboard and live ID inputs.
  always_comb begin
    squash   = (state_q == ST_FLUSH);
    slack    = ID_is_branch ? 32'd0 : 32'(EX_SLACK);
    hz_rs    = ID_uses_rs && (ID_RS != '0) && (32'(cnt_q[ID_RS]) > slack);
    hz_rt    = ID_uses_rt && (ID_RT != '0) && (32'(cnt_q[ID_RT]) > slack);
    stall    = ID_valid && !squash && (hz_rs || hz_rt);
    issue    = ID_valid && !stall && !squash;
    redirect = issue && (Branch || (|Jump));
  end

  // Pipeline control outputs.
  always_comb begin
    PCWrite     = !stall;
    IFIDWrite   = !stall;
    Hazard_Ctrl = stall;
    stall_cause = stall ? (ID_is_branch ? 2'b10 : 2'b01) : 2'b00;
    IF_Flush    = redirect || squash;
  end

  // Scoreboard next state: drain every counter, an issued write reloads its own.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue && ID_RegWrite && (ID_dst == REG_AW'(r)))
        cnt_d[r] = ID_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      else
        cnt_d[r] = '0;
    end
  end

  // Scoreboard registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  // Next-state logic; a single-cycle flush never enters FLUSH.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (stall) begin
          state_d = ST_STALL;
        end else if (redirect && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          fcnt_d  = 3'(FLUSH_CYCLES - 1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q - 3'd1;
        if (fcnt_q <= 3'd1) begin
          state_d = ST_RUN;
          fcnt_d  = 3'd0;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = 3'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_cycles_q, flush_cycles_d;
  logic [PERF_W-1:0] branch_stalls_q, branch_stalls_d;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    flush_cycles_d  = flush_cycles_q;
    branch_stalls_d = branch_stalls_q;
    if (stall && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    if (IF_Flush && !(&flush_cycles_q))
      flush_cycles_d = flush_cycles_q + PERF_W'(1);
    if (stall && ID_is_branch && !(&branch_stalls_q))
      branch_stalls_d = branch_stalls_q + PERF_W'(1);
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cycles_q  <= '0;
      flush_cycles_q  <= '0;
      branch_stalls_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      flush_cycles_q  <= flush_cycles_d;
      branch_stalls_q <= branch_stalls_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign flush_cycles  = flush_cycles_q;
  assign branch_stalls = branch_stalls_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: a directed sequence with literal expectations, then
// randomized traffic compared every cycle against a ready-time model.
module tb_hazard_scoreboard_unit;

  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int EX_SLACK = 1;
  localparam int FLUSH_N  = 3;
  localparam int PERF_W   = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ID_valid, ID_uses_rs, ID_uses_rt, ID_is_branch, ID_RegWrite, ID_is_load;
  logic [4:0] ID_RS, ID_RT, ID_dst;
  logic       Branch;
  logic [1:0] Jump;
  logic       PCWrite, IFIDWrite, IF_Flush, Hazard_Ctrl;
  logic [1:0] stall_cause;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles, flush_cycles, branch_stalls;
`endif

  hazard_scoreboard_unit #(
    .NUM_REGS(32), .REG_AW(5), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
    .EX_SLACK(EX_SLACK), .FLUSH_CYCLES(FLUSH_N)
`ifdef HAZARD_PERF_EN
    , .PERF_W(PERF_W)
`endif
  ) dut (
    .CLK(CLK), .RESET(RESET), .ID_valid(ID_valid), .ID_RS(ID_RS), .ID_RT(ID_RT),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt), .ID_is_branch(ID_is_branch),
    .ID_RegWrite(ID_RegWrite), .ID_is_load(ID_is_load), .ID_dst(ID_dst),
    .Branch(Branch), .Jump(Jump), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IF_Flush(IF_Flush), .Hazard_Ctrl(Hazard_Ctrl), .stall_cause(stall_cause)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles), .branch_stalls(branch_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  // Model: cycle at which each register's value becomes available with zero slack.
  longint avail [32];
  longint cyc;
  int     flush_left;
  longint m_stall_cnt, m_flush_cnt, m_br_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drv(input int v, input int rs, input int rt, input int urs, input int urt,
                     input int br, input int rw, input int ld, input int dst,
                     input int b, input int j);
    ID_valid = v[0]; ID_RS = rs[4:0]; ID_RT = rt[4:0];
    ID_uses_rs = urs[0]; ID_uses_rt = urt[0]; ID_is_branch = br[0];
    ID_RegWrite = rw[0]; ID_is_load = ld[0]; ID_dst = dst[4:0];
    Branch = b[0]; Jump = j[1:0];
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit hz(input logic [4:0] r, input logic u, input int slack);
    return u && (r != 0) && ((avail[r] - cyc) > slack);
  endfunction

  // Compare DUT against the model for the current cycle, then advance the model by one clock.
  task automatic tick();
    bit    squash, stall, issue, redirect, flush;
    int    slack;
    longint sat;
    squash   = (flush_left > 0);
    slack    = ID_is_branch ? 0 : EX_SLACK;
    stall    = ID_valid && !squash && (hz(ID_RS, ID_uses_rs, slack) || hz(ID_RT, ID_uses_rt, slack));
    issue    = ID_valid && !stall && !squash;
    redirect = issue && (Branch || (Jump != 0));
    flush    = redirect || squash;
    chk("PCWrite", PCWrite, !stall);
    chk("IFIDWrite", IFIDWrite, !stall);
    chk("Hazard_Ctrl", Hazard_Ctrl, stall);
    chk("IF_Flush", IF_Flush, flush);
    chk("stall_cause", stall_cause, !stall ? 0 : (ID_is_branch ? 2 : 1));
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall_cnt);
    chk("flush_cycles", flush_cycles, m_flush_cnt);
    chk("branch_stalls", branch_stalls, m_br_cnt);
`endif
    sat = (longint'(1) << PERF_W) - 1;
    if (RESET) begin
      for (int r = 0; r < 32; r++) avail[r] = 0;
      flush_left = 0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_br_cnt = 0;
    end else begin
      if (issue && ID_RegWrite && ID_dst != 0)
        avail[ID_dst] = cyc + (ID_is_load ? LOAD_LAT : ALU_LAT) + 1;
      if (squash) flush_left--;
      else if (redirect) flush_left = FLUSH_N - 1;
      if (stall && m_stall_cnt < sat) m_stall_cnt++;
      if (flush && m_flush_cnt < sat) m_flush_cnt++;
      if (stall && ID_is_branch && m_br_cnt < sat) m_br_cnt++;
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    cyc = 0; flush_left = 0;
    m_stall_cnt = 0; m_flush_cnt = 0; m_br_cnt = 0;
    for (int r = 0; r < 32; r++) avail[r] = 0;
    RESET = 1'b1;
    idle();
    @(posedge CLK);
    #1;

    // Reset state.
    #3;
    chk("rst_PCWrite", PCWrite, 1);
    chk("rst_IFIDWrite", IFIDWrite, 1);
    chk("rst_IF_Flush", IF_Flush, 0);
    chk("rst_Hazard_Ctrl", Hazard_Ctrl, 0);
    chk("rst_cause", stall_cause, 0);
    tick();
    RESET = 1'b0;

    // lw $8 ; add $9,$8,$1 -> one EX-operand stall.
    drv(1, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0); #3;
    chk("lw8_hz", Hazard_Ctrl, 0); tick();
    drv(1, 8, 1, 1, 1, 0, 1, 0, 9, 0, 0); #3;
    chk("add_stall_hz", Hazard_Ctrl, 1); chk("add_stall_pc", PCWrite, 0);
    chk("add_stall_cause", stall_cause, 1); tick();
    #3; chk("add_issue_hz", Hazard_Ctrl, 0); chk("add_issue_pc", PCWrite, 1); tick();

    // add $9 just issued ; beq $9,$2 -> one branch-operand stall.
    drv(1, 9, 2, 1, 1, 1, 0, 0, 0, 0, 0); #3;
    chk("beq_alu_hz", Hazard_Ctrl, 1); chk("beq_alu_cause", stall_cause, 2); tick();
    #3; chk("beq_alu_go", Hazard_Ctrl, 0); tick();

    // lw $8 ; beq $8 taken -> two stalls, flush only after the stall clears.
    drv(1, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0); #3; tick();
    drv(1, 8, 2, 1, 1, 1, 0, 0, 0, 1, 0); #3;
    chk("beq_ld_s1", Hazard_Ctrl, 1); chk("beq_ld_f1", IF_Flush, 0); tick();
    #3; chk("beq_ld_s2", Hazard_Ctrl, 1); chk("beq_ld_f2", IF_Flush, 0); tick();
    #3; chk("beq_ld_go", Hazard_Ctrl, 0); chk("redir_f1", IF_Flush, 1); tick();
    drv(1, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0); #3;
    chk("redir_f2", IF_Flush, 1); chk("squash_pc", PCWrite, 1); tick();
    drv(1, 10, 0, 1, 0, 0, 1, 0, 11, 0, 0); #3;
    chk("redir_f3", IF_Flush, 1); chk("squash_hz", Hazard_Ctrl, 0); tick();
    #3; chk("redir_end", IF_Flush, 0); chk("squashed_lw_hz", Hazard_Ctrl, 0); tick();

    // lw $0 ; add using $0 ; add $8 ; sw base $8 -> no stalls.
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); #3; tick();
    drv(1, 0, 0, 1, 1, 0, 1, 0, 12, 0, 0); #3; chk("r0_hz", Hazard_Ctrl, 0); tick();
    drv(1, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0); #3; tick();
    drv(1, 8, 3, 1, 1, 0, 0, 0, 0, 0, 0); #3; chk("sw_hz", Hazard_Ctrl, 0); tick();

    // RESET during a load stall aborts it.
    drv(1, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0); #3; tick();
    drv(1, 8, 0, 1, 0, 0, 1, 0, 9, 0, 0); RESET = 1'b1; #3;
    chk("rst_mid_hz", Hazard_Ctrl, 1); tick();
    RESET = 1'b0; #3;
    chk("post_rst_pc", PCWrite, 1); chk("post_rst_hz", Hazard_Ctrl, 0);
`ifdef HAZARD_PERF_EN
    chk("post_rst_perf", stall_cycles, 0);
`endif
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 99) == 0);
      drv(($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0) ? $urandom_range(1, 3) : 0);
      #3;
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
